// File: rtl/timer_bank.sv
// timer_bank: NUM_CH independent programmable timers. Each channel has a
// run-time period, a periodic or one-shot mode, and a one-cycle registered
// time_up pulse. Optional sticky expiry status is enabled by defining
// TIMER_BANK_STICKY_EN (adds status_clr input and status output).
module timer_bank #(
  parameter int          NUM_CH         = 4,
  parameter int          CNT_W          = 32,
  parameter int unsigned DEFAULT_PERIOD = 50000000
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      enable,
  input  logic [NUM_CH-1:0]                         start,
  input  logic [NUM_CH-1:0]                         stop,
  input  logic                                      cfg_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]                          cfg_period,
  input  logic                                      cfg_oneshot,
`ifdef TIMER_BANK_STICKY_EN
  input  logic [NUM_CH-1:0]                         status_clr,
  output logic [NUM_CH-1:0]                         status,
`endif
  output logic [NUM_CH-1:0]                         time_up,
  output logic [NUM_CH-1:0]                         active
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  logic [CNT_W-1:0] r_period  [NUM_CH];
  logic             r_oneshot [NUM_CH];
  logic [CNT_W-1:0] r_count   [NUM_CH];
  state_t           r_state   [NUM_CH];
  logic [NUM_CH-1:0] r_time_up;
  logic [NUM_CH-1:0] w_cfg_hit;

  // Decode which channel a config write addresses; out-of-range writes hit none.
  always_comb begin
    w_cfg_hit = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_cfg_hit[i] = cfg_we && (32'(cfg_ch) == i);
    end
  end

  // Per-channel period/mode registers, written by the config port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_period[i]  <= CNT_W'(DEFAULT_PERIOD);
        r_oneshot[i] <= 1'b0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (w_cfg_hit[i]) begin
          r_period[i]  <= cfg_period;
          r_oneshot[i] <= cfg_oneshot;
        end
      end
    end
  end

  // Channel FSM: stop beats start, start restarts, a zero period halts a
  // running channel, terminal compare is >= so a shrunk period fires at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_count[i] <= '0;
        r_state[i] <= S_IDLE;
      end
      r_time_up <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_time_up[i] <= 1'b0;
        if (stop[i]) begin
          r_state[i] <= S_IDLE;
          r_count[i] <= '0;
        end else if (start[i]) begin
          r_count[i] <= '0;
          r_state[i] <= (r_period[i] != '0) ? S_RUN : S_IDLE;
        end else if (r_state[i] == S_RUN) begin
          if (r_period[i] == '0) begin
            r_state[i] <= S_IDLE;
            r_count[i] <= '0;
          end else if (enable) begin
            if (r_count[i] >= r_period[i] - CNT_W'(1)) begin
              r_time_up[i] <= 1'b1;
              r_count[i]   <= '0;
              if (r_oneshot[i]) begin
                r_state[i] <= S_IDLE;
              end
            end else begin
              r_count[i] <= r_count[i] + CNT_W'(1);
            end
          end
        end
      end
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    time_up = r_time_up;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      active[i] = (r_state[i] == S_RUN);
    end
  end

`ifdef TIMER_BANK_STICKY_EN
  logic [NUM_CH-1:0] r_status;

  // Sticky expiry flags: a pulse sets, a clear resets, set wins on collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_status <= '0;
    end else begin
      r_status <= (r_status & ~status_clr) | r_time_up;
    end
  end

  assign status = r_status;
`endif

  logic [CH_W-1:0] w_unused_ch;
  assign w_unused_ch = cfg_ch;

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: directed test-plan scenarios plus a
// randomized phase, all checked against an elapsed-cycle reference model.
module tb_timer_bank;

  localparam int NUM_CH = 5;
  localparam int CNT_W  = 16;
  localparam int DEFP   = 10;
  localparam int CH_W   = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [NUM_CH-1:0] start, stop;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_period;
  logic              cfg_oneshot;
  logic [NUM_CH-1:0] time_up, active;
`ifdef TIMER_BANK_STICKY_EN
  logic [NUM_CH-1:0] status_clr, status;
`endif

  timer_bank #(
    .NUM_CH        (NUM_CH),
    .CNT_W         (CNT_W),
    .DEFAULT_PERIOD(DEFP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .start      (start),
    .stop       (stop),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_oneshot(cfg_oneshot),
`ifdef TIMER_BANK_STICKY_EN
    .status_clr (status_clr),
    .status     (status),
`endif
    .time_up    (time_up),
    .active     (active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: elapsed enabled cycles since (re)start per channel.
  int                m_period  [NUM_CH];
  bit                m_oneshot [NUM_CH];
  bit                m_run     [NUM_CH];
  int                m_el      [NUM_CH];
  logic [NUM_CH-1:0] m_tu;
  logic [NUM_CH-1:0] m_status;

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_period[i] = DEFP; m_oneshot[i] = 0; m_run[i] = 0; m_el[i] = 0;
    end
    m_tu = '0;
    m_status = '0;
  endtask

  task automatic model_update();
    logic [NUM_CH-1:0] tu_old;
    tu_old = m_tu;
    for (int i = 0; i < NUM_CH; i++) begin
      m_tu[i] = 1'b0;
      if (stop[i]) begin
        m_run[i] = 0; m_el[i] = 0;
      end else if (start[i]) begin
        m_run[i] = (m_period[i] != 0); m_el[i] = 0;
      end else if (m_run[i]) begin
        if (m_period[i] == 0) begin
          m_run[i] = 0; m_el[i] = 0;
        end else if (enable) begin
          m_el[i]++;
          if (m_el[i] >= m_period[i]) begin
            m_tu[i] = 1'b1; m_el[i] = 0;
            if (m_oneshot[i]) m_run[i] = 0;
          end
        end
      end
    end
`ifdef TIMER_BANK_STICKY_EN
    m_status = (m_status & ~status_clr) | tu_old;
`endif
    if (cfg_we && int'(cfg_ch) < NUM_CH) begin
      m_period[cfg_ch]  = int'(cfg_period);
      m_oneshot[cfg_ch] = cfg_oneshot;
    end
  endtask

  function automatic logic [NUM_CH-1:0] model_active();
    logic [NUM_CH-1:0] a;
    for (int i = 0; i < NUM_CH; i++) a[i] = m_run[i];
    return a;
  endfunction

  // One clock: advance the model on the current inputs, compare after the
  // edge, then drop all single-cycle pulses.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check("time_up", 32'(time_up), 32'(m_tu));
    check("active", 32'(active), 32'(model_active()));
`ifdef TIMER_BANK_STICKY_EN
    check("status", 32'(status), 32'(m_status));
    status_clr = '0;
`endif
    start = '0; stop = '0; cfg_we = 1'b0;
  endtask

  task automatic cfg(input int ch, input int per, input bit os);
    cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_period = CNT_W'(per); cfg_oneshot = os;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; start = '0; stop = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_oneshot = 1'b0;
`ifdef TIMER_BANK_STICKY_EN
    status_clr = '0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_time_up", 32'(time_up), 32'h0);
    check("reset_active", 32'(active), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Idle: nothing moves.
    repeat (3) step();
    check("idle_time_up", 32'(time_up), 32'h0);

    // ch0 period 5 periodic: pulses after E5, E10, E15.
    cfg(0, 5, 0); step();
    start[0] = 1'b1; step();
    for (int k = 1; k <= 15; k++) begin
      step();
      check("p5_pulse", 32'(time_up[0]), 32'((k % 5) == 0));
      check("p5_active", 32'(active[0]), 32'h1);
    end

    // ch1 period 3 one-shot: single pulse after E3, active falls with it.
    cfg(1, 3, 1); step();
    start[1] = 1'b1; step();
    for (int k = 1; k <= 20; k++) begin
      step();
      check("os_pulse", 32'(time_up[1]), 32'(k == 3));
      check("os_active", 32'(active[1]), 32'(k < 3));
    end

    // ch0 period 4 with two enable-low cycles: pulse delayed to E6.
    cfg(0, 4, 0); start[0] = 1'b1; step();
    for (int k = 1; k <= 8; k++) begin
      enable = !(k == 3 || k == 4);
      step();
      check("en_gap_pulse", 32'(time_up[0]), 32'(k == 6));
    end
    enable = 1'b1;
    // count is 2 here; restart and expect the pulse 4 edges later.
    start[0] = 1'b1; step();
    for (int k = 1; k <= 4; k++) begin
      step();
      check("restart_pulse", 32'(time_up[0]), 32'(k == 4));
    end

    // ch2 at count 7, shrink period to 3: pulse next cycle, then every 3.
    cfg(2, 20, 0); step();
    start[2] = 1'b1; step();
    repeat (7) step();
    cfg(2, 3, 0); step();
    for (int k = 1; k <= 7; k++) begin
      step();
      check("shrink_pulse", 32'(time_up[2]), 32'(k == 1 || k == 4 || k == 7));
    end
    cfg(2, 0, 0); step();
    step();
    check("zero_period_stop", 32'(active[2]), 32'h0);
    cfg(2, 3, 0); step();
    start[2] = 1'b1; stop[2] = 1'b1; step();
    check("start_stop_idle", 32'(active[2]), 32'h0);

    // Out-of-range config write must not disturb any channel.
    cfg(6, 1, 1); step();
    cfg(7, 2, 1); step();

    // Start everything, then assert reset asynchronously mid-count.
    start = '1; step();
    repeat (3) step();
    #2 reset = 1'b1;
    #1;
    check("async_rst_time_up", 32'(time_up), 32'h0);
    check("async_rst_active", 32'(active), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    start[3] = 1'b1; step();
    for (int k = 1; k <= 12; k++) begin
      step();
      check("default_period", 32'(time_up[3]), 32'(k == 10));
    end

`ifdef TIMER_BANK_STICKY_EN
    // ch0 period 2: status sets on the pulse and stays; clear collides with a pulse.
    cfg(0, 2, 0); step();
    start[0] = 1'b1; step();
    repeat (3) step();
    check("sticky_set", 32'(status[0]), 32'h1);
    repeat (1) step();
    status_clr[0] = 1'b1;
    step();
    check("sticky_collide", 32'(status[0]), 32'h1);
    stop[0] = 1'b1; step();
    step();
    status_clr[0] = 1'b1; step();
    check("sticky_clear", 32'(status[0]), 32'h0);
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 2500; c++) begin
      enable = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < NUM_CH; i++) begin
        start[i] = ($urandom_range(0, 15) == 0);
        stop[i]  = ($urandom_range(0, 31) == 0);
      end
      if ($urandom_range(0, 7) == 0) begin
        cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 9)), bit'($urandom_range(0, 1)));
      end
`ifdef TIMER_BANK_STICKY_EN
      for (int i = 0; i < NUM_CH; i++) status_clr[i] = ($urandom_range(0, 7) == 0);
`endif
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
